// File: rtl/branch_pkg.sv
// Shared types and constants for the branch execute stage.
package branch_pkg;

    // Link value written for JAL/JALR is the address of the next instruction.
    localparam int LINK_OFFSET = 4;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_op_e;

    // Decoded branch bundle as delivered by branch decode (non-operand fields).
    typedef struct packed {
        logic        is_nop;
        logic        is_jmp;
        logic        is_imm_type;
        logic        zero_ext;
        br_op_e      op;
        logic [4:0]  rd;
        logic [19:0] imm;
    } br_req_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator (EQ/NE/LT/GE, signed or unsigned).
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  br_op_e          op,
    input  logic            zero_ext,
    output logic            cond_true
);

    logic lt;

    assign lt = zero_ext ? (a < b) : ($signed(a) < $signed(b));

    // Select the condition for the requested compare op.
    always_comb begin
        cond_true = 1'b0;
        case (op)
            BR_EQ:   cond_true = (a == b);
            BR_NE:   cond_true = (a != b);
            BR_LT:   cond_true = lt;
            BR_GE:   cond_true = !lt;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_execute.sv
// Branch execute stage: resolves condition and target, produces link writeback,
// issues a one-shot redirect and squashes the wrong-path shadow behind it.
module branch_execute
    import branch_pkg::*;
#(
    parameter int SHADOW_SLOTS = 1,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_is_nop,
    input  logic            in_is_jmp,
    input  logic            in_is_imm_type,
    input  logic            in_zero_ext,
    input  logic [1:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [19:0]     in_imm,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_wb_en,
    output logic [4:0]      out_wb_rd,
    output logic [XLEN-1:0] out_wb_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] SQ_LOAD = 2'(SHADOW_SLOTS);

    br_req_t         req;
    logic [1:0]      sq_cnt;
    logic            accept;
    logic            squash;
    logic            illegal;
    logic            eff_nop;
    logic            cond_true;
    logic            taken;
    logic            wb_en;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;

    assign req = '{is_nop:      in_is_nop,
                   is_jmp:      in_is_jmp,
                   is_imm_type: in_is_imm_type,
                   zero_ext:    in_zero_ext,
                   op:          br_op_e'(in_op),
                   rd:          in_rd,
                   imm:         in_imm};

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .a         (in_rs1_val),
        .b         (in_rs2_val),
        .op        (req.op),
        .zero_ext  (req.zero_ext),
        .cond_true (cond_true)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Anything arriving while shadow slots remain is on the wrong path.
    assign squash   = (sq_cnt != 2'd0);
    // A register-relative target without a jump is not a legal encoding; drop it.
    assign illegal  = !req.is_jmp && req.is_imm_type;
    assign eff_nop  = req.is_nop || illegal || squash;

    assign taken    = !eff_nop && (req.is_jmp || cond_true);
    assign wb_en    = !eff_nop && req.is_jmp && (req.rd != 5'd0);

    assign imm_sx   = {{(XLEN-20){req.imm[19]}}, req.imm};
    assign jalr_sum = in_rs1_val + imm_sx;
    assign target   = (req.is_jmp && req.is_imm_type) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                      : in_pc + (imm_sx << 1);
    assign link     = in_pc + XLEN'(LINK_OFFSET);

    // Output register, redirect pulse and shadow-slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_wb_en      <= 1'b0;
            out_wb_rd      <= '0;
            out_wb_data    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            sq_cnt         <= '0;
        end else if (flush) begin
            // Flush wins over a same-cycle accept; the input is dropped.
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            sq_cnt         <= '0;
        end else begin
            // Pulse only at the accepting edge so a stalled result never re-fires.
            redirect_valid <= accept && taken;
            if (accept) begin
                out_valid   <= 1'b1;
                out_taken   <= taken;
                out_wb_en   <= wb_en;
                out_wb_rd   <= req.rd;
                out_wb_data <= link;
                if (taken) begin
                    redirect_pc <= target;
                    sq_cnt      <= SQ_LOAD;
                end else if (squash) begin
                    sq_cnt      <= sq_cnt - 2'd1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // Flag the illegal non-jump register-relative encoding when it is consumed.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && accept && !req.is_nop)
            assert (!illegal) else $error("branch_execute: is_imm_type without is_jmp");
    end
`endif

endmodule

// File: doc/branch_execute.md
Name: branch_execute

Overview:
- Execute stage directly downstream of branch decode. Consumes the decoded branch/jump fields plus register-file operand values and the instruction PC.
- Resolves taken/not-taken and the target address, and produces link-register writeback for JAL/JALR.
- Issues a one-shot front-end redirect and squashes a fixed number of wrong-path slots behind a taken branch.
- Valid/ready handshake on both sides; one-entry output register.

Parameters:
- SHADOW_SLOTS, 1, number of accepted instructions after a redirect that are converted to NOPs (0..3).
- XLEN, 32, datapath width for PC, operands and link data.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  external pipeline flush; clears the entry and the squash counter
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_is_nop  in  1  decoded NOP
- in_is_jmp  in  1  JAL/JALR
- in_is_imm_type  in  1  JALR (register-relative target)
- in_zero_ext  in  1  unsigned compare
- in_op  in  2  compare op: 00 EQ, 01 NE, 10 LT, 11 GE
- in_rd  in  5  link destination
- in_imm  in  20  decoded immediate (sign-extended by decode where applicable)
- in_rs1_val  in  XLEN  rs1 operand value
- in_rs2_val  in  XLEN  rs2 operand value
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_taken  out  1  control transfer taken
- out_wb_en  out  1  link write enable
- out_wb_rd  out  5  link destination
- out_wb_data  out  XLEN  link value, in_pc+4
- redirect_valid  out  1  single-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, out_taken, out_wb_en and redirect_valid are 0.
  - out_wb_rd, out_wb_data and redirect_pc are 0.
  - Squash counter is 0 and the redirect-issued flag is clear.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs on in_valid && in_ready. Output fields load at that edge, so latency is 1 cycle.
  - If out_valid && !out_ready, all out_* fields hold stable.
  - out_valid clears at an edge with out_ready high and no new accept.
- Target computation:
  - Conditional branch (!is_jmp): target = in_pc + (sext20(in_imm) << 1).
  - JAL (is_jmp && !is_imm_type): target = in_pc + (sext20(in_imm) << 1).
  - JALR (is_jmp && is_imm_type): target = (in_rs1_val + sext20(in_imm)) with bit 0 forced to 0.
  - All additions are mod 2^XLEN; wrap-around is silent.
- Condition:
  - EQ and NE use bitwise equality.
  - LT and GE compare signed when in_zero_ext=0 and unsigned when in_zero_ext=1.
  - Jumps are always taken.
- Link writeback: out_wb_en = is_jmp && (in_rd != 0); out_wb_data = in_pc + 4.
- NOP (in_is_nop=1):
  - Loads out_valid=1 with taken=0, wb_en=0 and no redirect.
  - in_is_nop has priority over every other field.
- Redirect:
  - redirect_valid pulses high for exactly one cycle: the cycle after accepting a taken, non-squashed instruction. redirect_pc equals the target.
  - The pulse does not repeat while the result stalls on out_ready.
- Squash:
  - At the redirect-producing accept edge, the counter loads SHADOW_SLOTS.
  - Each later accept while counter > 0 is converted to a NOP (taken=0, wb_en=0, no redirect) and decrements the counter.
  - The counter is not decremented on cycles without an accept.
  - A squashed instruction never reloads the counter.
- Flush:
  - Synchronous: clears out_valid, the squash counter and any pending redirect pulse at the next edge.
  - Overrides a simultaneous accept; the input is dropped and in_ready is still reported.
- Simultaneous accept and out_ready with out_valid: the old result retires and the new result loads in the same edge. Full throughput is 1 per cycle.
- Reset mid-stall discards the held entry and any pending redirect.
- Illegal condition: in_is_jmp=0 && in_is_imm_type=1 is treated as NOP. Simulation-only assertion fires.

Decomposition:
- branch_pkg holds:
  - typedef enum for op (BR_EQ, BR_NE, BR_LT, BR_GE);
  - packed struct for the decoded branch bundle;
  - constant LINK_OFFSET=4.
- Sub-module branch_compare (combinational): operands, op and zero_ext in; cond_true out. Instantiated once.

Test Plan:
- BEQ, pc=0x100, imm=0x00008, rs1=rs2=5, out_ready=1 -> next cycle out_taken=1, redirect_valid one cycle, redirect_pc=0x110, wb_en=0.
- BLTU with zero_ext=1, rs1=0xFFFF_FFFF, rs2=1 -> out_taken=0, no redirect. Same operands as BLT signed -> taken=1.
- JALR, pc=0x200, rs1=0x1001, imm=0x00003, rd=1 -> redirect_pc=0x1004, wb_en=1, wb_rd=1, wb_data=0x204.
- Taken JAL followed by two back-to-back valid branches that would also be taken, SHADOW_SLOTS=1 -> first follower squashed (taken=0, no redirect); second follower redirects normally.
- Taken branch with out_ready=0 for 3 cycles -> outputs stable, redirect_valid high only in the first cycle, in_ready=0 throughout.
- flush asserted the same cycle as a valid accept while the squash counter is 1 -> next cycle out_valid=0, counter 0; the next taken branch redirects.
